// File: rtl/rsp_framer.sv
// ============================================================================
// Module      : rsp_framer
// Description : Streams one response frame (two start bytes, 16-bit count,
//               BRAM payload, stop byte) to a ready/valid byte transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rsp_framer #(
    parameter logic [7:0] START_BYTE1 = 8'h19,
    parameter logic [7:0] START_BYTE2 = 8'h1E,
    parameter logic [7:0] STOP_BYTE   = 8'h1C
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic        start,
    input  logic [11:0] start_addr,
    input  logic [15:0] byte_count,
    output logic [11:0] rdaddr,
    output logic        rden,
    input  logic [7:0]  rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic [3:0]  stateop
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_HDR1   = 4'd1,
        S_HDR2   = 4'd2,
        S_CNTH   = 4'd3,
        S_CNTL   = 4'd4,
        S_RDREQ  = 4'd5,
        S_RDWAIT = 4'd6,
        S_DATA   = 4'd7,
        S_STOP   = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [11:0] rdaddr_q, rdaddr_d;
    logic        rden_q, rden_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Every output is computed one cycle ahead so the ports come straight from flops.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rdaddr_d   = rdaddr_q;
        rden_d     = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d     = start_addr;
                    cnt_d      = byte_count;
                    state_d    = S_HDR1;
                    tx_data_d  = START_BYTE1;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            S_HDR1: begin
                if (tx_ready) begin
                    state_d   = S_HDR2;
                    tx_data_d = START_BYTE2;
                end
            end
            S_HDR2: begin
                if (tx_ready) begin
                    state_d   = S_CNTH;
                    tx_data_d = cnt_q[15:8];
                end
            end
            S_CNTH: begin
                if (tx_ready) begin
                    state_d   = S_CNTL;
                    tx_data_d = cnt_q[7:0];
                end
            end
            S_CNTL: begin
                if (tx_ready) begin
                    if (cnt_q == 16'd0) begin
                        state_d   = S_STOP;
                        tx_data_d = STOP_BYTE;
                    end else begin
                        state_d    = S_RDREQ;
                        tx_valid_d = 1'b0;
                        rden_d     = 1'b1;
                        rdaddr_d   = addr_q;
                    end
                end
            end
            S_RDREQ: begin
                state_d = S_RDWAIT;
            end
            S_RDWAIT: begin
                state_d    = S_DATA;
                tx_data_d  = rdata;
                tx_valid_d = 1'b1;
            end
            S_DATA: begin
                if (tx_ready) begin
                    addr_d = addr_q + 12'd1;
                    cnt_d  = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d   = S_STOP;
                        tx_data_d = STOP_BYTE;
                    end else begin
                        state_d    = S_RDREQ;
                        tx_valid_d = 1'b0;
                        rden_d     = 1'b1;
                        rdaddr_d   = addr_q + 12'd1;
                    end
                end
            end
            S_STOP: begin
                if (tx_ready) begin
                    state_d    = S_IDLE;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q    <= S_IDLE;
            addr_q     <= 12'd0;
            cnt_q      <= 16'd0;
            rdaddr_q   <= 12'd0;
            rden_q     <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rdaddr_q   <= rdaddr_d;
            rden_q     <= rden_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rdaddr   = rdaddr_q;
    assign rden     = rden_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign stateop  = state_q;

endmodule

`default_nettype wire
